// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: RISC-V load/store width codes,
// stage FSM states and access-size helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam logic [2:0] MIS_MASK_B = 3'b000;
    localparam logic [2:0] MIS_MASK_H = 3'b001;
    localparam logic [2:0] MIS_MASK_W = 3'b011;
    localparam logic [2:0] MIS_MASK_D = 3'b111;

    // Codes without a legal meaning for the bus width fall back to a word access.
    function automatic size_e f3_size(input logic [2:0] funct3, input logic has_dword);
        size_e sz;
        case (funct3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_D:        sz = has_dword ? SZ_D : SZ_W;
            F3_W, F3_WU: sz = SZ_W;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [2:0] mis_mask(input size_e sz);
        logic [2:0] m;
        case (sz)
            SZ_B:    m = MIS_MASK_B;
            SZ_H:    m = MIS_MASK_H;
            SZ_W:    m = MIS_MASK_W;
            SZ_D:    m = MIS_MASK_D;
            default: m = MIS_MASK_W;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational lane logic: byte enables, replicated store data,
// extended load data and misalignment detection for one access.
module lsu_fmt
    import mem_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int SEL_W  = DATA_W / 8,
    localparam int OFF_W  = $clog2(SEL_W)
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] st_data_sh,
    output logic [DATA_W-1:0] ld_data,
    output logic              misaligned
);

    size_e             sz_s;
    logic [2:0]        addr3_s;
    logic [DATA_W-1:0] rd_sh_s;
    logic [DATA_W-1:0] ext_mask_s;
    logic [7:0]        sel_base_s;
    logic              sgn_s;

    assign sz_s       = f3_size(funct3, DATA_W == 64);
    assign addr3_s    = 3'(addr_lo);
    assign misaligned = |(addr3_s & mis_mask(sz_s));
    assign rd_sh_s    = rd_data >> {addr_lo, 3'b000};
    assign sel        = SEL_W'(sel_base_s) << addr_lo;
    assign ld_data    = (rd_sh_s & ext_mask_s) | ({DATA_W{sgn_s}} & ~ext_mask_s);

    // Per-size lane pattern, store replication and load extension controls
    always_comb begin
        sel_base_s = 8'h0F;
        st_data_sh = st_data;
        ext_mask_s = {DATA_W{1'b1}};
        sgn_s      = 1'b0;
        case (sz_s)
            SZ_B: begin
                sel_base_s = 8'h01;
                st_data_sh = {SEL_W{st_data[7:0]}};
                ext_mask_s = DATA_W'(8'hFF);
                sgn_s      = ~funct3[2] & rd_sh_s[7];
            end
            SZ_H: begin
                sel_base_s = 8'h03;
                st_data_sh = {(SEL_W/2){st_data[15:0]}};
                ext_mask_s = DATA_W'(16'hFFFF);
                sgn_s      = ~funct3[2] & rd_sh_s[15];
            end
            SZ_W: begin
                sel_base_s = 8'h0F;
                st_data_sh = {(SEL_W/4){st_data[31:0]}};
                ext_mask_s = DATA_W'(32'hFFFF_FFFF);
                sgn_s      = ~funct3[2] & rd_sh_s[31];
            end
            SZ_D: begin
                sel_base_s = 8'hFF;
                st_data_sh = st_data;
                ext_mask_s = {DATA_W{1'b1}};
                sgn_s      = 1'b0;
            end
            default: begin
                sel_base_s = 8'h0F;
                st_data_sh = st_data;
                ext_mask_s = {DATA_W{1'b1}};
                sgn_s      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem_wb.sv
// Registered memory stage: issues one Wishbone classic access per accepted
// load/store, forwards ALU results, and reports misalign/fault exceptions.
module stage_mem_wb
    import mem_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  ADDR_W  = 32,
    parameter int  TIMEOUT = 255,
    localparam int SEL_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              kill_i,
    input  logic              is_ld_mem_i,
    input  logic              is_st_mem_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [DATA_W-1:0] mem_fwd_dat_o,
    output logic              e_ld_addr_mis_o,
    output logic              e_st_addr_mis_o,
    output logic              e_ld_fault_o,
    output logic              e_st_fault_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    output logic [ADDR_W-1:0] wbm_addr_o
);

    localparam int OFF_W = $clog2(SEL_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_r, state_nxt_s;
    logic              accept_s, fault_s, tmo_hit_s;
    logic [2:0]        fmt_f3_s, funct3_r;
    logic [OFF_W-1:0]  fmt_lo_s, addr_lo_r;
    logic [SEL_W-1:0]  fmt_sel_s, sel_r;
    logic [DATA_W-1:0] fmt_st_s, fmt_ld_s, wdat_r, mem_data_r, fwd_r;
    logic              fmt_mis_s;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              cyc_r, we_r, is_ld_r, killed_r, valid_r;
    logic              ld_mis_r, st_mis_r, ld_flt_r, st_flt_r;

    // In IDLE the formatter sees the incoming op; afterwards the op held for the bus.
    assign fmt_f3_s = (state_r == IDLE) ? funct3_i : funct3_r;
    assign fmt_lo_s = (state_r == IDLE) ? mem_addr_i[OFF_W-1:0] : addr_lo_r;

    lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
        .funct3     (fmt_f3_s),
        .addr_lo    (fmt_lo_s),
        .st_data    (mem_data_i),
        .rd_data    (wbm_dat_i),
        .sel        (fmt_sel_s),
        .st_data_sh (fmt_st_s),
        .ld_data    (fmt_ld_s),
        .misaligned (fmt_mis_s)
    );

    assign tmo_hit_s = (TIMEOUT > 0) && (cnt_r == CNT_W'(TIMEOUT - 1));

    // Next-state logic; err outranks ack, and a bus response outranks the watchdog
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        fault_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_i && !kill_i) begin
                    accept_s = 1'b1;
                    if ((is_ld_mem_i || is_st_mem_i) && !fmt_mis_s) begin
                        state_nxt_s = BUS;
                    end else begin
                        state_nxt_s = RESP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUS: begin
                if (wbm_err_i) begin
                    fault_s     = 1'b1;
                    state_nxt_s = RESP;
                end else if (wbm_ack_i) begin
                    state_nxt_s = RESP;
                end else if (tmo_hit_s) begin
                    fault_s     = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUS;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Bus request, result and exception registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_r <= 1'b0;  we_r <= 1'b0;  sel_r <= '0;  wdat_r <= '0;  addr_r <= '0;
            funct3_r <= 3'b000;  addr_lo_r <= '0;  is_ld_r <= 1'b0;  killed_r <= 1'b0;
            cnt_r <= '0;  valid_r <= 1'b0;  mem_data_r <= '0;  fwd_r <= '0;
            ld_mis_r <= 1'b0;  st_mis_r <= 1'b0;  ld_flt_r <= 1'b0;  st_flt_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (accept_s) begin
                funct3_r  <= funct3_i;
                addr_lo_r <= mem_addr_i[OFF_W-1:0];
                is_ld_r   <= is_ld_mem_i;
                killed_r  <= 1'b0;
                fwd_r     <= DATA_W'(mem_addr_i);
                ld_mis_r  <= is_ld_mem_i & fmt_mis_s;
                st_mis_r  <= ~is_ld_mem_i & is_st_mem_i & fmt_mis_s;
                ld_flt_r  <= 1'b0;
                st_flt_r  <= 1'b0;
                if (state_nxt_s == BUS) begin
                    cyc_r  <= 1'b1;
                    we_r   <= ~is_ld_mem_i;
                    sel_r  <= fmt_sel_s;
                    wdat_r <= fmt_st_s;
                    addr_r <= {mem_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                    cnt_r  <= '0;
                end else begin
                    valid_r <= 1'b1;
                end
            end else if (state_r == BUS) begin
                if (kill_i) begin
                    killed_r <= 1'b1;
                end
                if (state_nxt_s == RESP) begin
                    cyc_r    <= 1'b0;
                    valid_r  <= ~(killed_r | kill_i);
                    ld_flt_r <= fault_s & is_ld_r;
                    st_flt_r <= fault_s & ~is_ld_r;
                    if (!fault_s && is_ld_r) begin
                        mem_data_r <= fmt_ld_s;
                        fwd_r      <= fmt_ld_s;
                    end
                end else if (cnt_r != {CNT_W{1'b1}}) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign stall_o         = valid_i && (state_r != IDLE);
    assign valid_o         = valid_r & ~kill_i;
    assign e_ld_addr_mis_o = ld_mis_r & valid_o;
    assign e_st_addr_mis_o = st_mis_r & valid_o;
    assign e_ld_fault_o    = ld_flt_r & valid_o;
    assign e_st_fault_o    = st_flt_r & valid_o;
    assign mem_data_o      = mem_data_r;
    assign mem_fwd_dat_o   = fwd_r;
    assign wbm_cyc_o       = cyc_r;
    assign wbm_stb_o       = cyc_r;
    assign wbm_we_o        = we_r;
    assign wbm_sel_o       = sel_r;
    assign wbm_dat_o       = wdat_r;
    assign wbm_addr_o      = addr_r;

endmodule

// File: tb/tb_stage_mem_wb.sv
// Bench for stage_mem_wb: directed scenarios plus randomized ops checked
// against a byte-arithmetic reference model and a scripted Wishbone slave.
module tb_stage_mem_wb;

    localparam int DATA_W = 32, ADDR_W = 32, TIMEOUT = 4, SEL_W = 4;
    localparam int M_ACK = 0, M_ERR = 1, M_ERRACK = 2, M_HANG = 3;

    logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, kill_i = 1'b0;
    logic is_ld_mem_i = 1'b0, is_st_mem_i = 1'b0;
    logic [2:0] funct3_i = 3'b000;
    logic [31:0] mem_data_i = 32'h0, mem_addr_i = 32'h0, wbm_dat_i = 32'h0;
    logic wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic stall_o, valid_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o;
    logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0] wbm_sel_o;
    logic [31:0] mem_data_o, mem_fwd_dat_o, wbm_dat_o, wbm_addr_o;

    int vec_cnt = 0, err_cnt = 0;

    // observations of the last op
    bit obs_valid, obs_done, obs_we;
    int obs_lat, obs_cyc, obs_stall;
    logic [3:0] obs_sel, obs_e;
    logic [31:0] obs_dat, obs_addr, obs_mem, obs_fwd;

    // model expectations
    bit exp_bus, exp_fault;
    int exp_cyc, exp_lat;
    logic [3:0] exp_sel, exp_e;
    logic [31:0] exp_dat, exp_addr, exp_ld, exp_fwd;

    always #5 clk = ~clk;

    stage_mem_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .kill_i(kill_i),
        .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i), .funct3_i(funct3_i),
        .mem_data_i(mem_data_i), .mem_addr_i(mem_addr_i), .stall_o(stall_o), .valid_o(valid_o),
        .mem_data_o(mem_data_o), .mem_fwd_dat_o(mem_fwd_dat_o),
        .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
        .e_ld_fault_o(e_ld_fault_o), .e_st_fault_o(e_st_fault_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o), .wbm_addr_o(wbm_addr_o)
    );

    // Reference model: access size in bytes from the width code
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        else if (f3[1:0] == 2'd1) return 2;
        else return 4;
    endfunction

    task automatic predict(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input int mode, input int wait_n);
        int nb, off;
        bit mis;
        logic [31:0] m;
        nb  = nbytes(f3);
        off = int'(addr[1:0]);
        mis = (ld || st) && ((off % nb) != 0);
        exp_bus   = (ld || st) && !mis;
        exp_fault = exp_bus && (mode != M_ACK);
        exp_cyc   = !exp_bus ? 0 : ((mode == M_HANG) ? TIMEOUT : wait_n + 1);
        exp_lat   = exp_cyc + 1;
        exp_sel   = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) exp_dat[8*i +: 8] = data[8*(i % nb) +: 8];
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_ld    = rdata >> (8 * off);
        if (nb < 4) begin
            m = (32'd1 << (8 * nb)) - 32'd1;
            exp_ld = exp_ld & m;
            if (!f3[2] && exp_ld[8*nb-1]) exp_ld = exp_ld | ~m;
        end
        exp_fwd = (ld && exp_bus && !exp_fault) ? exp_ld : addr;
        exp_e   = {ld && mis, st && mis, ld && exp_fault, st && exp_fault};
    endtask

    // Present one op (held until the stage frees up) and act as the Wishbone slave
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int mode,
                          input int wait_n, input int kill_cyc);
        bit resp;
        @(negedge clk);
        valid_i = 1'b1; is_ld_mem_i = ld; is_st_mem_i = st; funct3_i = f3;
        mem_addr_i = addr; mem_data_i = data;
        obs_valid = 0; obs_done = 0; obs_lat = 0; obs_cyc = 0; obs_stall = 0; obs_e = 4'h0;
        @(negedge clk);
        for (int k = 1; k <= 30 && !obs_done; k++) begin
            kill_i = (k == kill_cyc);
            #1;
            if (wbm_cyc_o) begin
                if (obs_cyc == 0) begin
                    obs_sel = wbm_sel_o; obs_dat = wbm_dat_o; obs_we = wbm_we_o; obs_addr = wbm_addr_o;
                end
                obs_cyc++;
                resp = (mode != M_HANG) && (obs_cyc > wait_n);
                wbm_ack_i = resp && (mode == M_ACK || mode == M_ERRACK);
                wbm_err_i = resp && (mode == M_ERR || mode == M_ERRACK);
                wbm_dat_i = rdata;
            end else begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            end
            if (stall_o) obs_stall++;
            if (valid_o) begin
                obs_valid = 1; obs_done = 1; obs_lat = k;
                obs_e = {e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o};
                obs_mem = mem_data_o; obs_fwd = mem_fwd_dat_o;
            end else if (!stall_o) begin
                obs_done = 1;
            end
            if (obs_done) begin
                valid_i = 1'b0; kill_i = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        vec_cnt++;
        if (!obs_done) begin
            err_cnt++;
            $display("FAIL op_bound got=busy exp=idle within 30 cycles");
            valid_i = 1'b0; kill_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_addr_o, valid_o, stall_o,
             mem_data_o, mem_fwd_dat_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o} !== '0) begin
            err_cnt++; $display("FAIL reset_outputs got=nonzero exp=all zero");
        end
        valid_i = 1'b0; rst_i = 1'b0;
    endtask

    task automatic test_lw();
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, M_ACK, 0, 0);
        vec_cnt++; if (obs_lat !== 2) begin err_cnt++; $display("FAIL lw_latency got=%0d exp=2", obs_lat); end
        vec_cnt++; if (obs_mem !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL lw_data got=%h exp=deadbeef", obs_mem); end
        vec_cnt++; if (obs_fwd !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL lw_fwd got=%h exp=deadbeef", obs_fwd); end
        vec_cnt++; if (obs_stall !== 2) begin err_cnt++; $display("FAIL lw_stall got=%0d exp=2", obs_stall); end
        vec_cnt++; if ({obs_sel, obs_we, obs_addr} !== {4'hF, 1'b0, 32'h100}) begin
            err_cnt++; $display("FAIL lw_bus got=sel %b we %b addr %h exp=sel 1111 we 0 addr 100", obs_sel, obs_we, obs_addr); end
    endtask

    task automatic test_lb();
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, M_ACK, 0, 0);
        vec_cnt++; if (obs_sel !== 4'b1000) begin err_cnt++; $display("FAIL lb_sel got=%b exp=1000", obs_sel); end
        vec_cnt++; if (obs_mem !== 32'hFFFFFF80) begin err_cnt++; $display("FAIL lb_data got=%h exp=ffffff80", obs_mem); end
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, M_ACK, 0, 0);
        vec_cnt++; if (obs_mem !== 32'h00000080) begin err_cnt++; $display("FAIL lbu_data got=%h exp=00000080", obs_mem); end
    endtask

    task automatic test_sh();
        run_op(0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, M_ACK, 1, 0);
        vec_cnt++; if (obs_sel !== 4'b1100) begin err_cnt++; $display("FAIL sh_sel got=%b exp=1100", obs_sel); end
        vec_cnt++; if (obs_dat !== 32'h12341234) begin err_cnt++; $display("FAIL sh_dat got=%h exp=12341234", obs_dat); end
        vec_cnt++; if ({obs_we, obs_addr} !== {1'b1, 32'h200}) begin err_cnt++; $display("FAIL sh_we_addr got=%b %h exp=1 200", obs_we, obs_addr); end
        vec_cnt++; if ({obs_valid, obs_e} !== 5'b10000) begin err_cnt++; $display("FAIL sh_resp got=%b%b exp=10000", obs_valid, obs_e); end
    endtask

    task automatic test_misalign();
        run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, M_ACK, 0, 0);
        vec_cnt++; if ({obs_cyc, obs_lat} !== {32'd0, 32'd1}) begin err_cnt++; $display("FAIL lmis_timing got=cyc %0d lat %0d exp=cyc 0 lat 1", obs_cyc, obs_lat); end
        vec_cnt++; if (obs_e !== 4'b1000) begin err_cnt++; $display("FAIL lmis_exc got=%b exp=1000", obs_e); end
        run_op(0, 1, 3'b010, 32'h102, 32'h55, 32'h0, M_ACK, 0, 0);
        vec_cnt++; if ({obs_cyc, obs_e} !== {32'd0, 4'b0100}) begin err_cnt++; $display("FAIL smis got=cyc %0d exc %b exp=cyc 0 exc 0100", obs_cyc, obs_e); end
    endtask

    task automatic test_fault();
        run_op(1, 0, 3'b010, 32'h104, 32'h0, 32'h0, M_HANG, 0, 0);
        vec_cnt++; if (obs_cyc !== TIMEOUT) begin err_cnt++; $display("FAIL tmo_cycles got=%0d exp=%0d", obs_cyc, TIMEOUT); end
        vec_cnt++; if ({obs_valid, obs_e} !== 5'b10010) begin err_cnt++; $display("FAIL tmo_exc got=%b%b exp=10010", obs_valid, obs_e); end
        run_op(1, 0, 3'b010, 32'h108, 32'h0, 32'h11223344, M_ACK, 0, 0);
        run_op(1, 0, 3'b010, 32'h10C, 32'h0, 32'h00000055, M_ERRACK, 0, 0);
        vec_cnt++; if (obs_e !== 4'b0010) begin err_cnt++; $display("FAIL errack_exc got=%b exp=0010", obs_e); end
        vec_cnt++; if (obs_mem !== 32'h11223344) begin err_cnt++; $display("FAIL errack_data got=%h exp=11223344", obs_mem); end
    endtask

    task automatic test_kill_store();
        run_op(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, M_ACK, 1, 1);
        vec_cnt++; if (obs_valid !== 1'b0) begin err_cnt++; $display("FAIL kill_valid got=%b exp=0", obs_valid); end
        vec_cnt++; if ({obs_cyc, obs_we, obs_dat} !== {32'd2, 1'b1, 32'hCAFEF00D}) begin
            err_cnt++; $display("FAIL kill_store got=cyc %0d we %b dat %h exp=cyc 2 we 1 dat cafef00d", obs_cyc, obs_we, obs_dat); end
    endtask

    task automatic test_passthrough();
        run_op(0, 0, 3'b010, 32'hABCD1234, 32'h0, 32'h0, M_ACK, 0, 0);
        vec_cnt++; if ({obs_lat, obs_cyc, obs_e} !== {32'd1, 32'd0, 4'b0000}) begin
            err_cnt++; $display("FAIL pass_resp got=lat %0d cyc %0d exc %b exp=1 0 0000", obs_lat, obs_cyc, obs_e); end
        vec_cnt++; if (obs_fwd !== 32'hABCD1234) begin err_cnt++; $display("FAIL pass_fwd got=%h exp=abcd1234", obs_fwd); end
    endtask

    task automatic test_random();
        bit ld, st, exp_valid;
        int sel_op, m, mode, wait_n, kc;
        logic [2:0] f3;
        logic [31:0] addr, data, rdata;
        for (int i = 0; i < 150; i++) begin
            sel_op = $urandom_range(0, 2);
            ld = (sel_op == 0); st = (sel_op == 1);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom; data = $urandom; rdata = $urandom;
            m = $urandom_range(0, 9);
            mode = (m < 7) ? M_ACK : (m == 7) ? M_ERR : (m == 8) ? M_ERRACK : M_HANG;
            wait_n = $urandom_range(0, 2);
            predict(ld, st, f3, addr, data, rdata, mode, wait_n);
            kc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, exp_cyc + 1) : 0;
            exp_valid = (kc == 0);
            run_op(ld, st, f3, addr, data, rdata, mode, wait_n, kc);
            vec_cnt++; if (obs_valid !== exp_valid) begin err_cnt++; $display("FAIL rnd_valid op=%0d got=%b exp=%b", i, obs_valid, exp_valid); end
            vec_cnt++; if (obs_cyc !== exp_cyc) begin err_cnt++; $display("FAIL rnd_cyc op=%0d got=%0d exp=%0d", i, obs_cyc, exp_cyc); end
            if (exp_valid && obs_valid) begin
                vec_cnt++; if (obs_lat !== exp_lat) begin err_cnt++; $display("FAIL rnd_lat op=%0d got=%0d exp=%0d", i, obs_lat, exp_lat); end
                vec_cnt++; if (obs_e !== exp_e) begin err_cnt++; $display("FAIL rnd_exc op=%0d got=%b exp=%b", i, obs_e, exp_e); end
                vec_cnt++; if (obs_fwd !== exp_fwd) begin err_cnt++; $display("FAIL rnd_fwd op=%0d got=%h exp=%h", i, obs_fwd, exp_fwd); end
                if (ld && exp_bus && !exp_fault) begin
                    vec_cnt++; if (obs_mem !== exp_ld) begin err_cnt++; $display("FAIL rnd_ld op=%0d f3=%b got=%h exp=%h", i, f3, obs_mem, exp_ld); end
                end
            end
            if (exp_bus && obs_cyc > 0) begin
                vec_cnt++; if ({obs_sel, obs_we, obs_addr} !== {exp_sel, st, exp_addr}) begin
                    err_cnt++; $display("FAIL rnd_bus op=%0d got=sel %b we %b addr %h exp=sel %b we %b addr %h",
                                        i, obs_sel, obs_we, obs_addr, exp_sel, st, exp_addr); end
                if (st) begin
                    vec_cnt++; if (obs_dat !== exp_dat) begin err_cnt++; $display("FAIL rnd_wdat op=%0d got=%h exp=%h", i, obs_dat, exp_dat); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        valid_i = 1'b1; is_ld_mem_i = 1'b1; is_st_mem_i = 1'b0; funct3_i = 3'b010; mem_addr_i = 32'h400;
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        vec_cnt++; if (wbm_cyc_o !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_cyc got=%b exp=1", wbm_cyc_o); end
        rst_i = 1'b1; kill_i = 1'b1;
        @(negedge clk);
        #1;
        vec_cnt++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_dat_o, wbm_addr_o, valid_o, stall_o,
             mem_data_o, mem_fwd_dat_o, e_ld_addr_mis_o, e_st_addr_mis_o, e_ld_fault_o, e_st_fault_o} !== '0) begin
            err_cnt++; $display("FAIL rst_mid_bus got=nonzero exp=all zero (cyc %b data %h)", wbm_cyc_o, mem_data_o);
        end
        rst_i = 1'b0; kill_i = 1'b0;
        run_op(1, 0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, M_ACK, 0, 0);
        vec_cnt++; if ({obs_lat, obs_mem} !== {32'd2, 32'h0BADF00D}) begin
            err_cnt++; $display("FAIL post_rst_lw got=lat %0d data %h exp=lat 2 data 0badf00d", obs_lat, obs_mem); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_misalign();
        test_fault();
        test_kill_store();
        test_passthrough();
        test_random();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
